// File: rtl/gpio_disp_pkg.sv
// Shared types and constants for the GPIO decimal display path.
package gpio_disp_pkg;

    // Conversion engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Segment patterns, active-low form, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Ten BCD nibbles cover the full 32-bit range; one shift per input bit
    localparam int BCD_DIGITS  = 10;
    localparam int BCD_W       = 40;
    localparam int SHIFT_COUNT = 32;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment pattern decoder.
// Dash wins over blank, blank wins over the digit value.
module seg7_decode
    import gpio_disp_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] pat_low;

    // Select the active-low pattern; non-decimal codes show blank
    always_comb begin
        pat_low = SEG_BLANK;
        if (dash) begin
            pat_low = SEG_DASH;
        end else if (!blank) begin
            case (digit)
                4'd0:    pat_low = SEG_0;
                4'd1:    pat_low = SEG_1;
                4'd2:    pat_low = SEG_2;
                4'd3:    pat_low = SEG_3;
                4'd4:    pat_low = SEG_4;
                4'd5:    pat_low = SEG_5;
                4'd6:    pat_low = SEG_6;
                4'd7:    pat_low = SEG_7;
                4'd8:    pat_low = SEG_8;
                4'd9:    pat_low = SEG_9;
                default: pat_low = SEG_BLANK;
            endcase
        end
    end

    assign seg = (ACTIVE_LOW != 0) ? pat_low : ~pat_low;

endmodule

// File: rtl/gpio_bcd_display.sv
// Drives the eight seven-segment displays from the CPU gpio_out value.
// A sequential double-dabble engine converts the value to BCD; the
// segment patterns are registered only when a conversion completes, so
// seg_out holds the previous result for the whole conversion.
// Handshake: valid rises with the first completed conversion and stays
// high; busy is high from LOAD until the DONE edge; value_in is sampled
// only in LOAD, and any later change is picked up by the next IDLE compare.
module gpio_bcd_display
    import gpio_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             value_in,
    output logic [NUM_DIGITS*7-1:0] seg_out,
    output logic                    busy,
    output logic                    valid,
    output logic                    ovf
);

    localparam logic [6:0] BLANK_PAT = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
    localparam logic [4:0] LAST_CNT  = 5'(SHIFT_COUNT - 1);

    state_t                  state;
    logic [31:0]             shreg;
    logic [31:0]             last_value;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcd_adj;
    logic [4:0]              count;
    logic                    pending_first;
    logic                    ovf_next;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS*7-1:0] seg_next;

    // Add-3 correction for every nibble that will overflow on the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Anything in the top two nibbles means the value needs more than 8 digits
    assign ovf_next = |bcd[BCD_W-1:4*NUM_DIGITS];

    // Blank every digit above the most significant nonzero one; digit 0 always shows
    always_comb begin
        blank_vec = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run & (bcd[4*k +: 4] == 4'd0);
            blank_vec[k] = (BLANK_LEADING != 0) && zero_run;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dec
            seg7_decode #(
                .ACTIVE_LOW(ACTIVE_LOW)
            ) u_dec (
                .digit(bcd[4*g +: 4]),
                .blank(blank_vec[g]),
                .dash (ovf_next),
                .seg  (seg_next[7*g +: 7])
            );
        end
    endgenerate

    // Conversion FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            last_value    <= '0;
            bcd           <= '0;
            count         <= '0;
            pending_first <= 1'b1;
            seg_out       <= {NUM_DIGITS{BLANK_PAT}};
            busy          <= 1'b0;
            valid         <= 1'b0;
            ovf           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending_first || (value_in != last_value)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg         <= value_in;
                    last_value    <= value_in;
                    bcd           <= '0;
                    count         <= '0;
                    busy          <= 1'b1;
                    pending_first <= 1'b0;
                    state         <= SHIFT;
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[BCD_W-2:0], shreg[31]};
                    shreg <= {shreg[30:0], 1'b0};
                    count <= count + 5'd1;
                    if (count == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    seg_out <= seg_next;
                    ovf     <= ovf_next;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Bench for gpio_bcd_display: directed values, expected segment images
// queued at stimulus time and checked by a monitor at each completion.
module tb_gpio_bcd_display;

    localparam int W = 57;   // {ovf, seg_out}
    localparam logic [6:0] B  = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;

    logic        clk;
    logic        rst;
    logic [31:0] value_in;
    logic [55:0] seg_out;
    logic        busy;
    logic        valid;
    logic        ovf;

    logic [W-1:0] exp_q[$];
    int tests;
    int failures;
    int busy_cnt;
    logic prev_busy;

    gpio_bcd_display #(
        .NUM_DIGITS   (8),
        .ACTIVE_LOW   (1),
        .BLANK_LEADING(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_in),
        .seg_out (seg_out),
        .busy    (busy),
        .valid   (valid),
        .ovf     (ovf)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Monitor: a completed conversion is busy falling while valid is high
    initial begin
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
            end else begin
                if (prev_busy && valid && !rst) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output: got ovf=%0b seg=%h, required no conversion", ovf, seg_out);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        if ({ovf, seg_out} !== e) begin
                            failures++;
                            $display("FAIL conv_result: got ovf=%0b seg=%h, required ovf=%0b seg=%h",
                                     ovf, seg_out, e[56], e[55:0]);
                        end
                    end
                    tests++;
                    if (busy_cnt != 33) begin
                        failures++;
                        $display("FAIL busy_length: got %0d cycles, required 33", busy_cnt);
                    end
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg"},   64'(seg_out), 64'({8{B}}));
        check({tag, "_busy"},  64'(busy),    64'd0);
        check({tag, "_valid"}, 64'(valid),   64'd0);
        check({tag, "_ovf"},   64'(ovf),     64'd0);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            failures++;
            $display("FAIL %s_timeout: %0d results pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic apply(input logic [31:0] v, input logic o, input logic [55:0] s, input string name);
        @(posedge clk);
        #2;
        value_in = v;
        exp_q.push_back({o, s});
        wait_drain(80, name);
    endtask

    // Directed stimulus
    initial begin
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        value_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");

        exp_q.push_back({1'b0, B, B, B, B, B, B, B, 7'h40});
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_drain(60, "zero");

        apply(32'd12345678, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, "v12345678");
        apply(32'd99999999, 1'b0, {8{7'h10}}, "v99999999");
        apply(32'd100000000, 1'b1, {8{DS}}, "v100000000");
        apply(32'hFFFFFFFF, 1'b1, {8{DS}}, "vmax");
        apply(32'd305, 1'b0, {B, B, B, B, B, 7'h30, 7'h40, 7'h12}, "v305");
        apply(32'd1000, 1'b0, {B, B, B, B, 7'h79, 7'h40, 7'h40, 7'h40}, "v1000");

        // Changes during a conversion: 5 shown, 7 skipped, 9 shown
        @(posedge clk);
        #2;
        value_in = 32'd5;
        exp_q.push_back({1'b0, B, B, B, B, B, B, B, 7'h12});
        exp_q.push_back({1'b0, B, B, B, B, B, B, B, 7'h10});
        repeat (10) @(posedge clk);
        #2;
        value_in = 32'd7;
        repeat (10) @(posedge clk);
        #2;
        value_in = 32'd9;
        wait_drain(150, "midconv");
        repeat (45) @(posedge clk);

        // Reset in the middle of a conversion of 42 (SHIFT count 15)
        @(posedge clk);
        #2;
        value_in = 32'd42;
        exp_q.push_back({1'b0, B, B, B, B, B, B, 7'h19, 7'h24});
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midreset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_drain(80, "restart42");

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
